baud_tick_gen: RTL
==================

# baud_tick_gen

Programmable UART baud-rate tick generator, the parametrised successor of the fixed-modulus `mod_m_counter`. It divides `clk` by a runtime-loadable divisor to produce an oversampling `sample_tick`. From that it derives `mid_tick`, a bit-centre pulse, and `bit_tick`, a bit-period pulse. It sits between the system clock and the UART RX/TX FSMs. RX uses `resync` to phase-align the tick train to a start-bit edge. An optional fractional divisor reduces baud error.

## Interface
Parameters:
- `N`, 8: divisor and counter width.
- `OVS`, 16: oversampling ratio. Even, ≥ 2.
- `DIV_RST`, 163: divisor value loaded at reset.

Ports:
- `clk`  input  1: the single clock. All logic is on the rising edge.
- `rst`  input  1: asynchronous, active-low reset.
- `en`  input  1: count enable.
- `div_load`  input  1: single-cycle strobe that captures `div_in` (and `frac_in`).
- `div_in`  input  N: new divisor D.
- `frac_in`  input  4: fractional divisor in sixteenths. Present only with `BAUD_GEN_FRAC_EN`.
- `resync`  input  1: restarts the tick phase.
- `q`  output  N: current count within the sample period.
- `ovs_cnt`  output  $clog2(OVS): count of sample ticks within the current bit.
- `sample_tick`  output  1: registered pulse, one per sample period.
- `mid_tick`  output  1: registered pulse at the bit centre.
- `bit_tick`  output  1: registered pulse at the end of each bit.

## Operation
- **Reset** (`rst`=0, asynchronous): `div_r`=DIV_RST, `q`=0, `ovs_cnt`=0, `sample_tick`=`mid_tick`=`bit_tick`=0, and (with the macro) `frac_r`=0, `acc`=0.
- **Effective divisor**: D = `div_r`, except that `div_r`=0 is treated as 1.
- **Sample event**: `en`=1 and `q`==P−1, where P is the current period (P = D, or D+1 when extended).
- **Counting**:
  - On a sample event: `q`←0, `sample_tick`←1, and `ovs_cnt` increments modulo OVS.
  - On any other cycle with `en`=1: `q`←`q`+1 and all ticks ←0.
- **`mid_tick`**: ←1 on a sample event where `ovs_cnt`==OVS/2−1.
- **`bit_tick`**: ←1 on a sample event where `ovs_cnt`==OVS−1; `ovs_cnt` then wraps to 0.
- **`en`=0**: `q` and `ovs_cnt` hold; all ticks ←0.
- **`div_load`**:
  - `div_r`←`div_in`, `q`←0, `ovs_cnt`←0, ticks ←0.
  - With the macro: `frac_r`←`frac_in` and `acc`←0.
  - Loading is accepted regardless of `en`.
- **`resync`**: `q`←0, `ovs_cnt`←0, ticks ←0. The divisor and `frac_r` are unchanged, and so is `acc`.
- **Priority**: `rst` > `div_load` > `resync` > `en`/count.
- **Boundary cases**:
  - `div_load` arriving on the same cycle as a would-be sample event suppresses that tick.
  - D=1 gives `sample_tick` high on every enabled cycle.
  - `q` never exceeds D−1 (or D with extension). After a divisor reduction, the counter restarts from 0, so wrap-around past N bits is impossible.
- **Reset mid-period**: the phase is lost and all outputs return to their reset values immediately. There is no glitch pulse.

## Timing
- Every tick output is registered and one cycle wide. Outputs have no combinational path from any input.
- After reset release, or after a `div_load`/`resync` edge, with `en` held at 1:
  - the first `sample_tick` is high in cycle D (counting the cycle after that edge as cycle 1);
  - subsequent `sample_tick` pulses arrive every D cycles.
- `mid_tick` coincides with the (OVS/2)-th `sample_tick`.
- `bit_tick` coincides with every OVS-th `sample_tick`; the bit period is OVS×D cycles.
- Deasserting `en` stretches the current period by exactly the number of disabled cycles.

## Configuration
- **`BAUD_GEN_FRAC_EN` defined**:
  - The `frac_in` port exists, together with 4-bit `frac_r` and a 4-bit accumulator `acc`.
  - On each sample event, `acc`←`acc`+`frac_r` (mod 16).
  - If that addition carries, the next sample period is D+1 cycles. The average period is D + `frac_r`/16.
- **Undefined**: no `frac_in` port and no accumulator; every period is exactly D cycles.

## Test plan
- Reset with DIV_RST=163 and `en`=1 → `sample_tick` first in cycle 163, then at cycle 326. All outputs are 0 while `rst`=0.
- `div_load` with `div_in`=4, OVS=16 → `sample_tick` at cycles 4, 8, 12, …; `mid_tick` at cycle 32; `bit_tick` at cycles 64 and 128, each coincident with a `sample_tick`.
- With D=4, drop `en` for 3 cycles mid-period → that `sample_tick` arrives 3 cycles late and `q` holds its value throughout.
- With D=4, pulse `resync` at cycle 30 → `ovs_cnt`=0, next `sample_tick` at cycle 34, `mid_tick` at cycle 62. Asserting `div_load` and `resync` together → the load wins and `div_r` updates.
- Set `div_in`=0 → `sample_tick` on every enabled cycle. Assert `div_load` on the cycle of a sample event → no tick that cycle.
- With `BAUD_GEN_FRAC_EN`, D=4, `frac_in`=8 → sample intervals 4, 4, 5, 4, 5, … averaging 4.5. Without the macro, every interval is 4.

Source files
------------

// File: rtl/baud_tick_gen.sv
// baud_tick_gen
//   Programmable UART baud-rate tick generator. Divides clk by a runtime
//   loadable divisor D to form an oversampling sample_tick, and derives a
//   bit-centre pulse (mid_tick) and a bit-end pulse (bit_tick) from it.
//
//   Optional feature macro: BAUD_GEN_FRAC_EN
//     Adds frac_in (sixteenths). A 4-bit accumulator gains frac_r on every
//     sample event; a carry stretches the following period to D+1 cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           count enable
//   div_load     one-cycle strobe capturing div_in (and frac_in)
//   div_in       new divisor D (0 behaves as 1)
//   frac_in      fractional divisor in sixteenths (BAUD_GEN_FRAC_EN only)
//   resync       restart the tick phase, divisor kept
//   q            count within the current sample period
//   ovs_cnt      sample ticks seen within the current bit
//   sample_tick  registered pulse, one per sample period
//   mid_tick     registered pulse at the bit centre
//   bit_tick     registered pulse at the end of each bit
module baud_tick_gen #(
    parameter int N       = 8,
    parameter int OVS     = 16,
    parameter int DIV_RST = 163
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    div_load,
    input  logic [N-1:0]            div_in,
`ifdef BAUD_GEN_FRAC_EN
    input  logic [3:0]              frac_in,
`endif
    input  logic                    resync,
    output logic [N-1:0]            q,
    output logic [$clog2(OVS)-1:0]  ovs_cnt,
    output logic                    sample_tick,
    output logic                    mid_tick,
    output logic                    bit_tick
);

    localparam int OW = $clog2(OVS);

    logic [N-1:0]  div_r;
    logic [N:0]    eff_div;     // one bit wider so D+1 never overflows
    logic [N:0]    period;
    logic          sample_evt;
    logic [OW-1:0] ovs_nxt;
    logic          mid_hit;
    logic          bit_hit;

`ifdef BAUD_GEN_FRAC_EN
    logic [3:0]    frac_r;
    logic [3:0]    acc;
    logic          ext;         // current period is stretched by one cycle
    logic [4:0]    acc_sum;
`endif

    always_comb begin
        eff_div = (div_r == '0) ? (N+1)'(1) : {1'b0, div_r};
`ifdef BAUD_GEN_FRAC_EN
        acc_sum = {1'b0, acc} + {1'b0, frac_r};
        period  = eff_div + (N+1)'(ext);
`else
        period  = eff_div;
`endif
        sample_evt = en && ({1'b0, q} == period - (N+1)'(1));
        bit_hit    = (ovs_cnt == OW'(OVS - 1));
        mid_hit    = (ovs_cnt == OW'(OVS / 2 - 1));
        ovs_nxt    = bit_hit ? '0 : ovs_cnt + OW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r       <= N'(DIV_RST);
            q           <= '0;
            ovs_cnt     <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_r      <= '0;
            acc         <= '0;
            ext         <= 1'b0;
`endif
        end else if (div_load) begin
            div_r       <= div_in;
            q           <= '0;
            ovs_cnt     <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            frac_r      <= frac_in;
            acc         <= '0;
            ext         <= 1'b0;
`endif
        end else if (resync) begin
            // Accumulator is kept; only the pending stretch is dropped so the
            // first period after resync is exactly D cycles.
            q           <= '0;
            ovs_cnt     <= '0;
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
`ifdef BAUD_GEN_FRAC_EN
            ext         <= 1'b0;
`endif
        end else if (sample_evt) begin
            q           <= '0;
            ovs_cnt     <= ovs_nxt;
            sample_tick <= 1'b1;
            mid_tick    <= mid_hit;
            bit_tick    <= bit_hit;
`ifdef BAUD_GEN_FRAC_EN
            acc         <= acc_sum[3:0];
            ext         <= acc_sum[4];
`endif
        end else begin
            if (en) begin
                q <= q + N'(1);
            end
            sample_tick <= 1'b0;
            mid_tick    <= 1'b0;
            bit_tick    <= 1'b0;
        end
    end

endmodule
